rfwild_pad_sched: RTL and testbench
===================================

# rfwild_pad_sched

Sequencer that time-shares the four bidirectional BC1520 contador pads between the counter (drive direction) and an external sampling client (receive direction). It owns the per-pad A/DE/RE controls and replaces static tie-high/tie-low configuration with a scheduled bus. It arbitrates between the two requesters and inserts turnaround cycles so the pad driver and an external driver never overlap. It sits between contador_rfwild and the pad ring in chip_rfwild.

## Interface
- WIDTH, 4: number of shared pads / data width
- TURN_CYC, 2: turnaround length in cycles, with DE=0 and RE=0; legal range ≥1
- DRIVE_MAX, 8: maximum consecutive DRIVE cycles while smp_req is pending; legal range ≥1

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-low
- drv_req  in  1  counter requests to drive pads (level)
- drv_data  in  WIDTH  value to drive (counter output)
- smp_req  in  1  client requests one pad sample (level)
- pad_z  in  WIDTH  pad receiver outputs (Z)
- pad_a  out  WIDTH  pad driver data (A)
- pad_de  out  WIDTH  driver enable, all bits equal
- pad_re  out  WIDTH  receiver enable, all bits equal
- drv_gnt  out  1  high in every DRIVE cycle
- smp_valid  out  1  one-cycle pulse, smp_data valid
- smp_data  out  WIDTH  captured pad value
- busy  out  1  state != IDLE

## Operation
- States: IDLE, DRIVE, SAMPLE, TURN. All outputs are registered.
- IDLE: DE=0, RE=0. If drv_req or smp_req is high, grant directly without a turnaround, because the bus is already released. When both are high, the round-robin pointer decides: the side not served last wins. After reset the pointer prefers drive.
- DRIVE: DE=1, RE=0, drv_gnt=1. pad_a=drv_data registered each cycle. Exit to TURN when:
  - drv_req is low, or
  - smp_req is high and drive_cnt reaches DRIVE_MAX.
  - If smp_req stays low, DRIVE length is unbounded.
- SAMPLE: RE=1, DE=0, always exactly 2 cycles. Cycle 1 is settle. At the end of cycle 2, pad_z is registered into smp_data, and smp_valid pulses in the following cycle. Exit is always to TURN.
- TURN: DE=0, RE=0 for exactly TURN_CYC cycles. Then arbitrate as in IDLE (round-robin), or go to IDLE if there are no requests. Every DRIVE or SAMPLE exit passes through TURN, including DRIVE→DRIVE re-grants.
- One SAMPLE serves one transaction. A smp_req still held afterwards is a new request.
- Counters:
  - turn_cnt width $clog2(TURN_CYC+1)
  - drive_cnt width $clog2(DRIVE_MAX+1), saturating at DRIVE_MAX, cleared on DRIVE entry
- pad_a holds its last value outside DRIVE.

## Timing
- Reset (reset=0 at an edge): the next cycle has every output at reset value:
  - pad_a=0, pad_de=0, pad_re=0
  - drv_gnt=0, smp_valid=0, smp_data=0, busy=0
  - state=IDLE, RR pointer=drive, counters=0
- Reset mid-DRIVE or mid-SAMPLE aborts immediately, with no TURN and no smp_valid.
- drv_req high in IDLE at cycle 0 → pad_de=1 and drv_gnt=1 from cycle 1. pad_a lags drv_data by one cycle.
- smp_req high in IDLE at cycle 0:
  - pad_re=1 in cycles 1–2
  - smp_valid=1 in cycle 3, with smp_data = pad_z sampled at the end of cycle 2
  - TURN in cycles 3..2+TURN_CYC
- DRIVE→SAMPLE turnaround: the last DE=1 cycle is n, TURN occupies n+1..n+TURN_CYC, and RE=1 starts at n+TURN_CYC+1.
- DE and RE are never high in the same cycle. DE never rises in the cycle after RE was high.

## Structure
- Shared package rfwild_pad_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, TURN)
  - default values for TURN_CYC and DRIVE_MAX
  - the RR pointer encoding
- Single module; the 2-way round-robin is inline. No sub-module is warranted.
- The chip top instantiates the block between contador_rfwild and the four BC1520 pads.

## Test plan
- Reset then drv_req=1 with drv_data=4'hA: cycle 1 DE=1, gnt=1; cycle 2 pad_a=4'hA. Drop drv_req: 2 TURN cycles, then IDLE with busy=0.
- smp_req pulse with pad_z=4'h5: RE=1 for exactly 2 cycles; smp_valid in the 3rd cycle with smp_data=4'h5.
- drv_req held, smp_req raised at drive cycle 3: DRIVE lasts 8 cycles total, then 2 TURN cycles, then SAMPLE. Afterwards DRIVE resumes via TURN.
- drv_req and smp_req both raised simultaneously from reset: DRIVE is granted first; on the next arbitration, SAMPLE wins.
- reset=0 in SAMPLE cycle 2: the next cycle has all outputs 0, state IDLE, and no smp_valid.
- Continuous assertion check: never DE&RE; never RE→DE in adjacent cycles; TURN length equals TURN_CYC.

Source files
------------

// File: rtl/rfwild_pad_pkg.sv
// Shared types and defaults for the BC1520 pad bus sequencer.
package rfwild_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  // Round-robin pointer names the side that wins the next tie.
  typedef enum logic {
    RR_DRIVE  = 1'b0,
    RR_SAMPLE = 1'b1
  } rr_t;

  localparam int unsigned TURN_CYC_DEF  = 2;
  localparam int unsigned DRIVE_MAX_DEF = 8;

endpackage

// File: rtl/rfwild_pad_sched.sv
// Time-shares the contador pads between counter drive and external sampling,
// inserting TURN_CYC dead cycles between every direction change.
module rfwild_pad_sched
  import rfwild_pad_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned TURN_CYC  = TURN_CYC_DEF,
  parameter int unsigned DRIVE_MAX = DRIVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             drv_req,
  input  logic [WIDTH-1:0] drv_data,
  input  logic             smp_req,
  input  logic [WIDTH-1:0] pad_z,
  output logic [WIDTH-1:0] pad_a,
  output logic [WIDTH-1:0] pad_de,
  output logic [WIDTH-1:0] pad_re,
  output logic             drv_gnt,
  output logic             smp_valid,
  output logic [WIDTH-1:0] smp_data,
  output logic             busy
);

  localparam int unsigned TW = $clog2(TURN_CYC + 1);
  localparam int unsigned DW = $clog2(DRIVE_MAX + 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYC - 1);
  localparam logic [DW-1:0] DRIVE_LAST = DW'(DRIVE_MAX - 1);
  localparam logic [DW-1:0] DRIVE_SAT  = DW'(DRIVE_MAX);

  state_t          state, state_nx;
  rr_t             rr, rr_nx;
  logic [TW-1:0]   turn_cnt;
  logic [DW-1:0]   drive_cnt;
  logic            samp_second;
  logic            de_q, re_q;

  logic            de_nx, re_nx, busy_nx, valid_nx;
  logic [WIDTH-1:0] data_nx, a_nx;

  // Outputs are registered from the next state so pad enables switch on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr          <= RR_DRIVE;
      turn_cnt    <= '0;
      drive_cnt   <= '0;
      samp_second <= 1'b0;
      de_q        <= 1'b0;
      re_q        <= 1'b0;
      busy        <= 1'b0;
      smp_valid   <= 1'b0;
      smp_data    <= '0;
      pad_a       <= '0;
    end else begin
      state       <= state_nx;
      rr          <= rr_nx;
      turn_cnt    <= (state == ST_TURN) ? turn_cnt + TW'(1) : '0;
      samp_second <= (state == ST_SAMPLE) && !samp_second;
      if (state_nx == ST_DRIVE && state != ST_DRIVE)
        drive_cnt <= '0;
      else if (state == ST_DRIVE && drive_cnt != DRIVE_SAT)
        drive_cnt <= drive_cnt + DW'(1);
      de_q        <= de_nx;
      re_q        <= re_nx;
      busy        <= busy_nx;
      smp_valid   <= valid_nx;
      smp_data    <= data_nx;
      pad_a       <= a_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    unique case (state)
      ST_IDLE, ST_TURN: begin
        if (state == ST_IDLE || turn_cnt == TURN_LAST) begin
          if (drv_req && (!smp_req || rr == RR_DRIVE)) begin
            state_nx = ST_DRIVE;
            rr_nx    = RR_SAMPLE;
          end else if (smp_req) begin
            state_nx = ST_SAMPLE;
            rr_nx    = RR_DRIVE;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      // drive_cnt is zero in the first DRIVE cycle, so DRIVE_LAST marks the
      // DRIVE_MAX-th consecutive cycle.
      ST_DRIVE:  if (!drv_req || (smp_req && drive_cnt >= DRIVE_LAST)) state_nx = ST_TURN;
      ST_SAMPLE: if (samp_second) state_nx = ST_TURN;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    de_nx    = (state_nx == ST_DRIVE);
    re_nx    = (state_nx == ST_SAMPLE);
    busy_nx  = (state_nx != ST_IDLE);
    valid_nx = (state == ST_SAMPLE) && samp_second;
    data_nx  = valid_nx ? pad_z : smp_data;
    a_nx     = (state == ST_DRIVE) ? drv_data : pad_a;
  end

  assign pad_de  = {WIDTH{de_q}};
  assign pad_re  = {WIDTH{re_q}};
  assign drv_gnt = de_q;

endmodule

// File: tb/tb_rfwild_pad_sched.sv
// Bench for rfwild_pad_sched: directed vector table, drive/sample handover
// sequences and randomized traffic against a cycle-level reference model.
module tb_rfwild_pad_sched;

  localparam int unsigned W  = 4;
  localparam int unsigned TC = 2;
  localparam int unsigned DM = 8;

  logic         clk = 1'b0;
  logic         reset, drv_req, smp_req;
  logic [W-1:0] drv_data, pad_z;
  logic [W-1:0] pad_a, pad_de, pad_re, smp_data;
  logic         drv_gnt, smp_valid, busy;

  always #5 clk = ~clk;

  rfwild_pad_sched #(.WIDTH(W), .TURN_CYC(TC), .DRIVE_MAX(DM)) dut (
    .clk(clk), .reset(reset), .drv_req(drv_req), .drv_data(drv_data),
    .smp_req(smp_req), .pad_z(pad_z), .pad_a(pad_a), .pad_de(pad_de),
    .pad_re(pad_re), .drv_gnt(drv_gnt), .smp_valid(smp_valid),
    .smp_data(smp_data), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who holds the bus, how long, and what is owed next.
  bit         m_driving, m_sampling, m_prefer_drive, m_valid, m_was_reset;
  int         m_gap_left, m_age, m_len;
  logic [W-1:0] m_a, m_data;

  bit prev_re;
  int gap_run;

  typedef struct {
    logic         rst_n, drv, smp;
    logic [W-1:0] dd, pz;
    logic         de, re, valid, busy;
    logic [W-1:0] a, data;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic rst_n, logic drv, logic [W-1:0] dd, logic smp,
                              logic [W-1:0] pz, logic de, logic re, logic valid,
                              logic bsy, logic [W-1:0] a, logic [W-1:0] data);
    vec_t v;
    v.rst_n = rst_n; v.drv = drv; v.dd = dd; v.smp = smp; v.pz = pz;
    v.de = de; v.re = re; v.valid = valid; v.busy = bsy; v.a = a; v.data = data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(logic [W-1:0] a, logic [W-1:0] d, logic [W-1:0] de,
                                       logic [W-1:0] re, logic g, logic v, logic b);
    return {13'd0, a, d, de, re, g, v, b};
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_driving = 0; m_sampling = 0; m_gap_left = 0; m_prefer_drive = 1;
      m_a = '0; m_data = '0; m_valid = 0; m_was_reset = 1;
      return;
    end
    m_was_reset = 0;
    m_valid     = 0;
    if (m_driving) begin
      m_a = drv_data;
      m_len++;
      if (!drv_req || (smp_req && m_len >= int'(DM))) begin
        m_driving = 0; m_gap_left = TC;
      end
    end else if (m_sampling) begin
      m_age++;
      if (m_age == 2) begin
        m_data = pad_z; m_valid = 1; m_sampling = 0; m_gap_left = TC;
      end
    end else if (m_gap_left > 1) begin
      m_gap_left--;
    end else begin
      m_gap_left = 0;
      if (drv_req && (!smp_req || m_prefer_drive)) begin
        m_driving = 1; m_len = 0; m_prefer_drive = 0;
      end else if (smp_req) begin
        m_sampling = 1; m_age = 0; m_prefer_drive = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", pack(pad_a, smp_data, pad_de, pad_re, drv_gnt, smp_valid, busy),
          pack(m_a, m_data, {W{m_driving}}, {W{m_sampling}}, m_driving, m_valid,
               m_driving || m_sampling || m_gap_left > 0));
    check("de_re_overlap", {31'd0, (|pad_de) && (|pad_re)}, 32'd0);
    check("re_then_de", {31'd0, prev_re && (|pad_de)}, 32'd0);
    if (m_was_reset) gap_run = 0;
    else if (busy && pad_de == '0 && pad_re == '0) gap_run++;
    else if (gap_run > 0) begin
      check("turn_len", gap_run, TC);
      gap_run = 0;
    end
    prev_re = |pad_re;
  endtask

  // Reset, then request drive; smp_req joins at cycle raise_at (0 = together).
  task automatic handover_seq(input int raise_at, input string name);
    logic de_h[17], re_h[17];
    int   de_count;
    reset = 0; drv_req = 0; smp_req = 0; drv_data = 4'h3; pad_z = 4'hC;
    step();
    reset = 1; drv_req = 1; smp_req = (raise_at == 0);
    for (int c = 1; c <= 16; c++) begin
      step();
      de_h[c] = |pad_de;
      re_h[c] = |pad_re;
      if (c == raise_at) smp_req = 1;
    end
    de_count = 0;
    for (int c = 1; c <= 8; c++) de_count += int'(de_h[c]);
    check({name, "_drive_len"}, de_count, 8);
    check({name, "_turn1"}, {30'd0, de_h[9] | re_h[9], de_h[10] | re_h[10]}, 32'd0);
    check({name, "_sample"}, {28'd0, re_h[10], re_h[11], re_h[12], re_h[13]}, 32'b0110);
    check({name, "_redrive"}, {29'd0, de_h[14], de_h[15], re_h[15]}, 32'b010);
    drv_req = 0; smp_req = 0;
  endtask

  initial begin
    reset = 0; drv_req = 0; smp_req = 0; drv_data = '0; pad_z = '0;
    prev_re = 0; gap_run = 0;

    //            rst drv dd    smp pz    de re vld bsy a     data
    tbl[0]  = mk(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    tbl[1]  = mk(1, 1, 4'hA, 0, 4'h0, 1, 0, 0, 1, 4'h0, 4'h0);
    tbl[2]  = mk(1, 1, 4'hA, 0, 4'h0, 1, 0, 0, 1, 4'hA, 4'h0);
    tbl[3]  = mk(1, 0, 4'hA, 0, 4'h0, 0, 0, 0, 1, 4'hA, 4'h0);
    tbl[4]  = mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'hA, 4'h0);
    tbl[5]  = mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'hA, 4'h0);
    tbl[6]  = mk(1, 0, 4'h0, 1, 4'h5, 0, 1, 0, 1, 4'hA, 4'h0);
    tbl[7]  = mk(1, 0, 4'h0, 0, 4'h5, 0, 1, 0, 1, 4'hA, 4'h0);
    tbl[8]  = mk(1, 0, 4'h0, 0, 4'h5, 0, 0, 1, 1, 4'hA, 4'h5);
    tbl[9]  = mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'hA, 4'h5);
    tbl[10] = mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'hA, 4'h5);
    tbl[11] = mk(1, 0, 4'h0, 1, 4'h9, 0, 1, 0, 1, 4'hA, 4'h5);
    tbl[12] = mk(1, 0, 4'h0, 0, 4'h9, 0, 1, 0, 1, 4'hA, 4'h5);
    tbl[13] = mk(0, 0, 4'h0, 0, 4'h9, 0, 0, 0, 0, 4'h0, 4'h0);
    tbl[14] = mk(1, 0, 4'h0, 0, 4'h9, 0, 0, 0, 0, 4'h0, 4'h0);

    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst_n; drv_req = tbl[i].drv; drv_data = tbl[i].dd;
      smp_req = tbl[i].smp; pad_z = tbl[i].pz;
      step();
      check($sformatf("vec%0d", i),
            pack(pad_a, smp_data, pad_de, pad_re, drv_gnt, smp_valid, busy),
            pack(tbl[i].a, tbl[i].data, {W{tbl[i].de}}, {W{tbl[i].re}},
                 tbl[i].de, tbl[i].valid, tbl[i].busy));
    end

    handover_seq(0, "both_at_once");
    handover_seq(3, "smp_at_cyc3");

    reset = 0; step();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) drv_req = ~drv_req;
      if ($urandom_range(0, 3) == 0) smp_req = ~smp_req;
      drv_data = W'($urandom);
      pad_z    = W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
